// File: rtl/teclado_pkg.sv
// Shared types and constants for the 4x4 keypad scan sequencer.
// Holds the scan state enum and the lowest-active-column encoder.
package teclado_pkg;

  localparam int FILAS   = 4;
  localparam int COLS    = 4;
  localparam int TECLA_W = 4;

  typedef enum logic [1:0] {
    BARRIDO,
    REBOTE,
    PRESIONADA,
    LIBERACION
  } estado_t;

  // Lowest set bit wins, so column 0 has priority when several columns are active.
  function automatic logic [1:0] bit_menor(input logic [COLS-1:0] v);
    logic [1:0] res;
    res = 2'd0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (v[i]) begin
        res = 2'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/teclado_tick_gen.sv
// Scan tick generator: one-cycle strobe every DIV clocks while hab_in is high.
// Dropping hab_in freezes the counter, so no tick is produced.
module teclado_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk_50,
  input  logic rst_n,
  input  logic hab_in,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = hab_in && (cnt == CNT_MAX);

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (hab_in) begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/teclado_control_barrido.sv
// Row scan, debounce and valid/ack key delivery for a 4x4 membrane keypad.
// Define TECLADO_AUTOREPEAT_EN to re-report a held key every REP_TICKS ticks.
module teclado_control_barrido
  import teclado_pkg::*;
#(
  parameter int DIV       = 50000,
  parameter int DEB_COUNT = 8
`ifdef TECLADO_AUTOREPEAT_EN
  ,
  parameter int REP_TICKS = 250
`endif
) (
  input  logic               clk_50,
  input  logic               rst_n,
  input  logic               hab_in,
  input  logic [COLS-1:0]    col_in,
  output logic [FILAS-1:0]   fila_out,
  output logic [1:0]         index_out,
  output logic [TECLA_W-1:0] tecla_out,
  output logic               valida_out,
  input  logic               ack_in,
  output logic               perdida_out
);

  localparam int DEB_W = (DEB_COUNT > 1) ? $clog2(DEB_COUNT) : 1;
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_COUNT - 1);

`ifdef TECLADO_AUTOREPEAT_EN
  localparam int REP_W = (REP_TICKS > 1) ? $clog2(REP_TICKS) : 1;
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REP_TICKS - 1);

  logic [REP_W-1:0] rep_cnt, rep_cnt_sig;
`endif

  logic            tick;
  logic [COLS-1:0] col_meta, col_sync, col_act;
  estado_t         estado, estado_sig;
  logic [1:0]      col_cap, col_cap_sig;
  logic [DEB_W-1:0] deb_cnt, deb_cnt_sig;
  logic [1:0]      index_sig;
  logic            carga;

  teclado_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk_50(clk_50),
    .rst_n (rst_n),
    .hab_in(hab_in),
    .tick  (tick)
  );

  // Columns idle high through the pull-ups, hence the all-ones reset.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  assign col_act = ~col_sync;

  always_comb begin
    estado_sig  = estado;
    col_cap_sig = col_cap;
    deb_cnt_sig = deb_cnt;
    index_sig   = index_out;
    carga       = 1'b0;
`ifdef TECLADO_AUTOREPEAT_EN
    rep_cnt_sig = rep_cnt;
`endif
    if (tick) begin
      case (estado)
        BARRIDO: begin
          if (col_act == '0) begin
            index_sig = index_out + 2'd1;
          end else begin
            col_cap_sig = bit_menor(col_act);
            deb_cnt_sig = '0;
            estado_sig  = REBOTE;
          end
        end
        REBOTE: begin
          if (col_act[col_cap]) begin
            if (deb_cnt == DEB_MAX) begin
              carga      = 1'b1;
              estado_sig = PRESIONADA;
`ifdef TECLADO_AUTOREPEAT_EN
              rep_cnt_sig = '0;
`endif
            end else begin
              deb_cnt_sig = deb_cnt + DEB_W'(1);
            end
          end else begin
            estado_sig = BARRIDO;
            index_sig  = index_out + 2'd1;
          end
        end
        PRESIONADA: begin
          if (!col_act[col_cap]) begin
            deb_cnt_sig = '0;
            estado_sig  = LIBERACION;
          end
`ifdef TECLADO_AUTOREPEAT_EN
          else if (rep_cnt == REP_MAX) begin
            carga       = 1'b1;
            rep_cnt_sig = '0;
          end else begin
            rep_cnt_sig = rep_cnt + REP_W'(1);
          end
`endif
        end
        LIBERACION: begin
          if (!col_act[col_cap]) begin
            if (deb_cnt == DEB_MAX) begin
              estado_sig = BARRIDO;
              index_sig  = index_out + 2'd1;
            end else begin
              deb_cnt_sig = deb_cnt + DEB_W'(1);
            end
          end else begin
            estado_sig = PRESIONADA;
`ifdef TECLADO_AUTOREPEAT_EN
            rep_cnt_sig = '0;
`endif
          end
        end
        default: estado_sig = BARRIDO;
      endcase
    end
  end

  // Row drive is registered from the next index so it always matches index_out.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= BARRIDO;
      col_cap   <= 2'd0;
      deb_cnt   <= '0;
      index_out <= 2'd0;
      fila_out  <= 4'b1110;
`ifdef TECLADO_AUTOREPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      estado    <= estado_sig;
      col_cap   <= col_cap_sig;
      deb_cnt   <= deb_cnt_sig;
      index_out <= index_sig;
      fila_out  <= ~(FILAS'(1) << index_sig);
`ifdef TECLADO_AUTOREPEAT_EN
      rep_cnt   <= rep_cnt_sig;
`endif
    end
  end

  // A load always beats an ack in the same cycle; overwriting an unread code flags a loss.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      tecla_out   <= '0;
      valida_out  <= 1'b0;
      perdida_out <= 1'b0;
    end else begin
      perdida_out <= 1'b0;
      if (carga) begin
        tecla_out   <= {index_out, col_cap};
        valida_out  <= 1'b1;
        perdida_out <= valida_out && !ack_in;
      end else if (ack_in && valida_out) begin
        valida_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_teclado_control_barrido.sv
// Scoreboard bench for teclado_control_barrido with a row-gated keypad model.
// Build with TECLADO_AUTOREPEAT_EN to exercise the repeat reports.
module tb_teclado_control_barrido;

  logic       clk_50 = 1'b0;
  logic       rst_n;
  logic       hab_in;
  logic [3:0] col_in;
  logic [3:0] fila_out;
  logic [1:0] index_out;
  logic [3:0] tecla_out;
  logic       valida_out;
  logic       ack_in;
  logic       perdida_out;

  logic       key_on;
  logic [1:0] key_row;
  logic [3:0] key_cols;

  int n_checks = 0;
  int n_errors = 0;
  int n_reports = 0;
  int perd_cnt = 0;
  int cyc = 0;
  int last_rep_cyc = 0;
  int prev_rep_cyc = 0;
  logic [3:0] exp_q[$];

  always #5 clk_50 = ~clk_50;

  // A pressed key pulls its columns low only while its row is driven low.
  assign col_in = (key_on && (fila_out[key_row] == 1'b0)) ? ~key_cols : 4'hF;

  teclado_control_barrido #(
    .DIV(4),
    .DEB_COUNT(3)
`ifdef TECLADO_AUTOREPEAT_EN
    ,
    .REP_TICKS(5)
`endif
  ) dut (
    .clk_50     (clk_50),
    .rst_n      (rst_n),
    .hab_in     (hab_in),
    .col_in     (col_in),
    .fila_out   (fila_out),
    .index_out  (index_out),
    .tecla_out  (tecla_out),
    .valida_out (valida_out),
    .ack_in     (ack_in),
    .perdida_out(perdida_out)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic on, input logic [1:0] row, input logic [3:0] cols);
    key_on   = on;
    key_row  = row;
    key_cols = cols;
  endtask

  task automatic waitIndex(input logic [1:0] v, input int max);
    logic [1:0] prev;
    bit found;
    found = 1'b0;
    prev  = index_out;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge clk_50);
      if (index_out == v && prev != v) found = 1'b1;
      prev = index_out;
    end
    checkOutput("wait_index", found, 1);
  endtask

  task automatic waitReport(input int max);
    int r0;
    bit found;
    r0    = n_reports;
    found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge clk_50);
      if (n_reports != r0) found = 1'b1;
    end
    checkOutput("report_seen", found, 1);
  endtask

  task automatic pulseAck();
    @(negedge clk_50);
    ack_in = 1'b1;
    @(negedge clk_50);
    ack_in = 1'b0;
    checkOutput("ack_clear", valida_out, 0);
  endtask

  // A new code is visible when valida rises, when it overwrites, or when it survives an ack.
  initial begin : monitor
    logic ack_e;
    logic valida_prev;
    logic [3:0] exp;
    valida_prev = 1'b0;
    forever begin
      @(posedge clk_50);
      ack_e = ack_in;
      #1;
      cyc++;
      if (perdida_out) perd_cnt++;
      if (valida_out && (!valida_prev || perdida_out || (ack_e && valida_prev))) begin
        n_reports++;
        prev_rep_cyc = last_rep_cyc;
        last_rep_cyc = cyc;
        checkOutput("report_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          checkOutput("tecla", tecla_out, exp);
        end
      end
      valida_prev = valida_out;
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int p0;
    rst_n  = 1'b0;
    hab_in = 1'b1;
    ack_in = 1'b0;
    applyStimulus(1'b0, 2'd0, 4'h0);

    // 1: reset values, then idle scan every 4 clocks
    repeat (3) @(negedge clk_50);
    checkOutput("rst_index", index_out, 0);
    checkOutput("rst_fila", fila_out, 4'b1110);
    checkOutput("rst_tecla", tecla_out, 0);
    checkOutput("rst_valida", valida_out, 0);
    checkOutput("rst_perdida", perdida_out, 0);
    rst_n = 1'b1;
    waitIndex(2'd1, 20);
    for (int k = 0; k < 5; k++) begin
      checkOutput("scan_index", index_out, (1 + k) % 4);
      checkOutput("scan_fila", fila_out, 4'(~(4'b0001 << ((1 + k) % 4))));
      repeat (4) @(negedge clk_50);
    end

    // 2: key on row 2 column 2, ack, hold without repeat, release
    applyStimulus(1'b1, 2'd2, 4'b0100);
    exp_q.push_back(4'hA);
    waitReport(100);
    pulseAck();
    repeat (6) @(negedge clk_50);
    checkOutput("held_no_report", valida_out, 0);
    checkOutput("held_index", index_out, 2);
    applyStimulus(1'b0, 2'd2, 4'b0100);
    waitIndex(2'd3, 60);

    // 3: one-tick bounce on row 1 must not report and must move on to row 2
    waitIndex(2'd1, 40);
    applyStimulus(1'b1, 2'd1, 4'b1000);
    repeat (5) @(negedge clk_50);
    applyStimulus(1'b0, 2'd1, 4'b1000);
    repeat (4) @(negedge clk_50);
    checkOutput("bounce_index", index_out, 2);
    checkOutput("bounce_valida", valida_out, 0);

    // 4a: second key before ack overwrites and pulses perdida once
    applyStimulus(1'b1, 2'd2, 4'b0100);
    exp_q.push_back(4'hA);
    waitReport(100);
    applyStimulus(1'b0, 2'd2, 4'b0100);
    waitIndex(2'd3, 60);
    applyStimulus(1'b1, 2'd0, 4'b0010);
    exp_q.push_back(4'h1);
    p0 = perd_cnt;
    waitReport(100);
    checkOutput("overwrite_valida", valida_out, 1);
    checkOutput("overwrite_perdida", perd_cnt - p0, 1);
    applyStimulus(1'b0, 2'd0, 4'b0010);
    waitIndex(2'd1, 60);

    // 4b: ack lands on the load edge (row reached + 4 ticks)
    applyStimulus(1'b1, 2'd3, 4'b1000);
    exp_q.push_back(4'hF);
    p0 = perd_cnt;
    waitIndex(2'd3, 40);
    repeat (15) @(negedge clk_50);
    ack_in = 1'b1;
    @(negedge clk_50);
    ack_in = 1'b0;
    applyStimulus(1'b0, 2'd3, 4'b1000);
    checkOutput("load_ack_valida", valida_out, 1);
    checkOutput("load_ack_tecla", tecla_out, 4'hF);
    checkOutput("load_ack_perdida", perd_cnt - p0, 0);
    checkOutput("load_ack_popped", exp_q.size(), 0);
    pulseAck();
    waitIndex(2'd0, 60);

    // 5: two columns on row 1 report the lowest, then reset mid-debounce
    applyStimulus(1'b1, 2'd1, 4'b0011);
    exp_q.push_back(4'h4);
    waitReport(100);
    applyStimulus(1'b0, 2'd1, 4'b0011);
    waitIndex(2'd2, 60);
    applyStimulus(1'b1, 2'd1, 4'b0011);
    waitIndex(2'd1, 40);
    repeat (7) @(negedge clk_50);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_index", index_out, 0);
    checkOutput("midrst_fila", fila_out, 4'b1110);
    checkOutput("midrst_tecla", tecla_out, 0);
    checkOutput("midrst_valida", valida_out, 0);
    checkOutput("midrst_perdida", perdida_out, 0);
    applyStimulus(1'b0, 2'd1, 4'b0011);
    repeat (3) @(negedge clk_50);
    rst_n = 1'b1;

    // 6: held key 5, repeat reports when enabled, then freeze the scan
    applyStimulus(1'b1, 2'd1, 4'b0010);
    exp_q.push_back(4'h5);
    waitReport(100);
    pulseAck();
`ifdef TECLADO_AUTOREPEAT_EN
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(4'h5);
      waitReport(40);
      checkOutput("repeat_spacing", last_rep_cyc - prev_rep_cyc, 20);
      pulseAck();
    end
`else
    repeat (40) @(negedge clk_50);
    checkOutput("single_report", valida_out, 0);
`endif
    applyStimulus(1'b0, 2'd1, 4'b0010);
    waitIndex(2'd2, 60);
    hab_in = 1'b0;
    repeat (40) @(negedge clk_50);
    checkOutput("freeze_index", index_out, 2);
    checkOutput("freeze_fila", fila_out, 4'b1011);
    checkOutput("freeze_valida", valida_out, 0);
    hab_in = 1'b1;
    repeat (3) @(negedge clk_50);
    checkOutput("resume_hold", index_out, 2);
    @(negedge clk_50);
    checkOutput("resume_step", index_out, 3);

    checkOutput("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
